// File: rtl/rf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rf_ctrl_pkg
//  Description : Shared sizes, FSM state encoding and helpers for the
//                register-file access controller.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_ctrl_pkg;

   localparam int NREG = 16;
   localparam int SELW = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BT   = 2'd1,
      ST_CLR  = 2'd2
   } state_t;

   // Number of set bits in a register list; loaded into the remaining-count
   function automatic logic [SELW:0] popcount(input logic [NREG-1:0] v);
      logic [SELW:0] n;
      n = '0;
      for (int i = 0; i < NREG; i++) begin
         n = n + {{SELW{1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rf_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : rf_access_ctrl_if
//  Description : Decode / block-transfer / register-file signal bundle for
//                rf_access_ctrl. master = requester side, slave = controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_access_ctrl_if;
   import rf_ctrl_pkg::*;

   // decode single access
   logic            ins_req;
   logic [SELW-1:0] ins_ra;
   logic [SELW-1:0] ins_rb;
   logic [SELW-1:0] ins_rc;
   logic            ins_we;
   logic            ins_gnt;
   // block-transfer sequencer
   logic            bt_start;
   logic            bt_load;
   logic [NREG-1:0] bt_list;
   logic            bt_xfer;
   logic [SELW-1:0] bt_idx;
   logic [SELW:0]   bt_cnt;
   logic            bt_busy;
   logic            bt_done;
   // register-file side
   logic [SELW-1:0] rf_ra;
   logic [SELW-1:0] rf_rb;
   logic [SELW-1:0] rf_rc;
   logic [SELW-1:0] rf_rd;
   logic            rf_we;
   logic            rf_clr;
   // clear sequence
   logic            clr_req;
   logic            clr_done;

   modport master (
      output ins_req, ins_ra, ins_rb, ins_rc, ins_we,
      output bt_start, bt_load, bt_list, bt_xfer, clr_req,
      input  ins_gnt, bt_idx, bt_cnt, bt_busy, bt_done,
      input  rf_ra, rf_rb, rf_rc, rf_rd, rf_we, rf_clr, clr_done
   );

   modport slave (
      input  ins_req, ins_ra, ins_rb, ins_rc, ins_we,
      input  bt_start, bt_load, bt_list, bt_xfer, clr_req,
      output ins_gnt, bt_idx, bt_cnt, bt_busy, bt_done,
      output rf_ra, rf_rb, rf_rc, rf_rd, rf_we, rf_clr, clr_done
   );

endinterface
`default_nettype wire

// File: rtl/rf_lowest_set_enc.sv
`default_nettype none
// ============================================================================
//  Module      : rf_lowest_set_enc
//  Description : Combinational priority encoder, lowest set bit of a register
//                list -> index, plus a non-empty flag.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_lowest_set_enc
   import rf_ctrl_pkg::*;
(
   input  logic [NREG-1:0] i_list,
   output logic [SELW-1:0] o_idx,
   output logic            o_valid
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (i_list[i]) begin
            o_idx   = SELW'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rf_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rf_access_ctrl
//  Description : Register-file access controller. Arbitrates the 16x32 file
//                between single decode accesses and an LDM/STM block-transfer
//                sequencer walking a register list in ascending order.
//                Optional clear sequence enabled by macro RF_CLEAR_SEQ_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_access_ctrl
   import rf_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   rf_access_ctrl_if.slave  bus
);

   state_t          r_state,  w_state_nxt;
   logic [NREG-1:0] r_pend,   w_pend_nxt;
   logic [SELW:0]   r_cnt,    w_cnt_nxt;
   logic [SELW-1:0] r_idx,    w_idx_nxt;
   logic [SELW-1:0] r_ra,     w_ra_nxt;
   logic [SELW-1:0] r_rb,     w_rb_nxt;
   logic [SELW-1:0] r_rc,     w_rc_nxt;
   logic            r_load,   w_load_nxt;
   logic            r_we,     w_we_nxt;
   logic            r_gnt,    w_gnt_nxt;
   logic            r_done,   w_done_nxt;

   logic [SELW-1:0] w_list_idx;
   logic            w_list_vld;
   logic [NREG-1:0] w_pend_clr;
   logic [SELW-1:0] w_rem_idx;
   logic            w_rem_vld;

`ifdef RF_CLEAR_SEQ_EN
   logic [SELW-1:0] r_rd,       w_rd_nxt;
   logic            r_clr,      w_clr_nxt;
   logic            r_clr_done, w_clr_done_nxt;
   localparam logic [SELW-1:0] c_last_rd = SELW'(NREG - 1);
`else
   logic            w_unused_clr_req;
   assign w_unused_clr_req = bus.clr_req;
`endif

   // First register of a newly started list
   rf_lowest_set_enc u_enc_list (
      .i_list  (bus.bt_list),
      .o_idx   (w_list_idx),
      .o_valid (w_list_vld)
   );

   // Pending list with the current register retired; empty means last transfer
   assign w_pend_clr = r_pend & ~(NREG'(1) << r_idx);

   rf_lowest_set_enc u_enc_pend (
      .i_list  (w_pend_clr),
      .o_idx   (w_rem_idx),
      .o_valid (w_rem_vld)
   );

   // Next-state and next register values; everything holds unless changed
   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_ra_nxt    = r_ra;
      w_rb_nxt    = r_rb;
      w_rc_nxt    = r_rc;
      w_load_nxt  = r_load;
      w_we_nxt    = 1'b0;
      w_gnt_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
`ifdef RF_CLEAR_SEQ_EN
      w_rd_nxt       = r_rd;
      w_clr_nxt      = 1'b0;
      w_clr_done_nxt = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.bt_start) begin
               if (w_list_vld) begin
                  w_state_nxt = ST_BT;
                  w_pend_nxt  = bus.bt_list;
                  w_cnt_nxt   = popcount(bus.bt_list);
                  w_idx_nxt   = w_list_idx;
                  w_load_nxt  = bus.bt_load;
                  if (bus.bt_load) begin
                     w_rc_nxt = w_list_idx;
                  end else begin
                     w_ra_nxt = w_list_idx;
                  end
               end else begin
                  // empty list completes immediately without going busy
                  w_done_nxt = 1'b1;
               end
            end
`ifdef RF_CLEAR_SEQ_EN
            else if (bus.clr_req) begin
               w_state_nxt = ST_CLR;
               w_clr_nxt   = 1'b1;
               w_rd_nxt    = '0;
            end
`endif
            else if (bus.ins_req) begin
               w_gnt_nxt = 1'b1;
               w_ra_nxt  = bus.ins_ra;
               w_rb_nxt  = bus.ins_rb;
               w_rc_nxt  = bus.ins_rc;
               w_we_nxt  = bus.ins_we;
            end
         end
         ST_BT: begin
            if (bus.bt_xfer) begin
               w_pend_nxt = w_pend_clr;
               w_cnt_nxt  = r_cnt - (SELW + 1)'(1);
               if (w_rem_vld) begin
                  w_idx_nxt = w_rem_idx;
                  if (r_load) begin
                     w_rc_nxt = w_rem_idx;
                  end else begin
                     w_ra_nxt = w_rem_idx;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
`ifdef RF_CLEAR_SEQ_EN
         ST_CLR: begin
            if (r_rd == c_last_rd) begin
               w_state_nxt    = ST_IDLE;
               w_clr_done_nxt = 1'b1;
            end else begin
               w_clr_nxt = 1'b1;
               w_rd_nxt  = r_rd + SELW'(1);
            end
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pend  <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_ra    <= '0;
         r_rb    <= '0;
         r_rc    <= '0;
         r_load  <= 1'b0;
         r_we    <= 1'b0;
         r_gnt   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_ra    <= w_ra_nxt;
         r_rb    <= w_rb_nxt;
         r_rc    <= w_rc_nxt;
         r_load  <= w_load_nxt;
         r_we    <= w_we_nxt;
         r_gnt   <= w_gnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

`ifdef RF_CLEAR_SEQ_EN
   // Clear-sequence registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd       <= '0;
         r_clr      <= 1'b0;
         r_clr_done <= 1'b0;
      end else begin
         r_rd       <= w_rd_nxt;
         r_clr      <= w_clr_nxt;
         r_clr_done <= w_clr_done_nxt;
      end
   end

   assign bus.rf_rd    = r_rd;
   assign bus.rf_clr   = r_clr;
   assign bus.clr_done = r_clr_done;
`else
   assign bus.rf_rd    = '0;
   assign bus.rf_clr   = 1'b0;
   assign bus.clr_done = 1'b0;
`endif

   assign bus.ins_gnt = r_gnt;
   assign bus.bt_idx  = r_idx;
   assign bus.bt_cnt  = r_cnt;
   assign bus.bt_busy = (r_state == ST_BT);
   assign bus.bt_done = r_done;
   assign bus.rf_ra   = r_ra;
   assign bus.rf_rb   = r_rb;
   assign bus.rf_rc   = r_rc;
   // Load writes follow the transfer strobe in the same cycle as the data
   assign bus.rf_we   = r_we | ((r_state == ST_BT) & r_load & bus.bt_xfer);

endmodule
`default_nettype wire
